lsq_disamb: RTL and testbench
=============================

LSQ_DISAMB -- requirements
Module: lsq_disamb

Interface
REQ-001 SHALL have parameters: DEPTH, default 8, entries (power of 2, >=4); DISP_W, default 3, dispatch ports; N_WB, default 3, writeback ports; PREG_W, default 5; TAG_W, default 5; ADDR_W, default 16.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset; ports in order:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
flush  in  1  clear all state.
disp_valid  in  [DISP_W]  per-port memory op present.
disp_is_store  in  [DISP_W]  1=store, 0=load.
disp_preg  in  [DISP_W][PREG_W]  store: data source preg; load: destination preg.
disp_preg_rdy  in  [DISP_W]  store data already available.
disp_tag  in  [DISP_W][TAG_W]  ROB tag.
disp_ready  out  1  room for DISP_W entries.
wb_valid  in  [N_WB]  result broadcast valid.
wb_preg  in  [N_WB][PREG_W]  broadcast preg.
agu_valid  in  1  address broadcast valid.
agu_tag  in  TAG_W  address owner tag.
agu_addr  in  ADDR_W  computed address.
iss_valid  out  1  issue slot valid.
iss_is_store  out  1  issued op type.
iss_preg  out  PREG_W  issued preg.
iss_addr  out  ADDR_W  issued address.
iss_tag  out  TAG_W  issued ROB tag.
iss_ready  in  1  consumer accepts issue.

Function
REQ-003 SHALL be a circular queue with head/tail pointers and occupancy count (0..DEPTH); disp_ready = (DEPTH - count >= DISP_W).
REQ-004 SHALL, when disp_ready, write valid dispatch ports compacted in port order to tail, tail+1, ... (modulo DEPTH); tail and count advance by number of valid ports; invalid ports create no hole.
REQ-005 SHALL set a load's data-ready bit to 1 at enqueue; a store's to disp_preg_rdy OR any same-cycle wb match on disp_preg.
REQ-006 SHALL set data-ready on any valid entry whose preg equals any valid wb_preg (all N_WB ports, same cycle).
REQ-007 SHALL, on agu_valid, set addr-valid and capture agu_addr in every valid entry with matching tag, including an entry enqueued that cycle.
REQ-008 SHALL make a store eligible only when it is the oldest valid entry, data-ready and addr-valid.
REQ-009 SHALL make a load eligible when addr-valid and every older valid store is addr-valid with address not equal (full ADDR_W compare) to the load's.
REQ-010 SHALL select the oldest eligible entry (age from head) when the issue register is empty or iss_ready=1 that cycle; selected entry is invalidated the same edge.
REQ-011 SHALL register the issue output: iss_* hold stable while iss_valid=1 and iss_ready=0; iss_valid drops next cycle after acceptance if nothing eligible.
REQ-012 SHALL advance head each cycle past all leading invalid entries up to tail; count decreases accordingly; holes left by out-of-order loads occupy capacity until passed.
REQ-013 SHALL give flush priority over dispatch, wakeup and issue: next cycle all entries invalid, head=tail=0, count=0, iss_valid=0.
REQ-014 SHALL accept dispatch, wakeup, AGU and issue in the same cycle; freeing and enqueue are combined in count update.

Reset
REQ-015 SHALL on rst=0 asynchronously clear all entry state, head, tail, count, and drive iss_valid=0, iss_is_store=0, iss_preg=0, iss_addr=0, iss_tag=0; disp_ready=1 after reset.

Structure
REQ-016 SHALL place the entry struct (valid, is_store, data_rdy, addr_vld, preg, addr, tag) and parameter defaults in shared package lsq_pkg.
REQ-017 SHALL use one sub-module lsq_age_picker: DEPTH-bit request vector plus head pointer in, one-hot/index of oldest request and found flag out.

Verification
REQ-018 Reset then 3 loads (tags 1,2,3), AGU tag2 addr 0x0040 -> tag2 issues first, iss_addr=0x0040.
REQ-019 Store tag4 (addr 0x0100) older than load tag5 (addr 0x0200), both addr-valid, store data not ready -> load issues; store issues only after wb_preg match.
REQ-020 Same setup with load addr 0x0100 -> load blocked until store issues, then load issues next eligible cycle.
REQ-021 DEPTH=8, DISP_W=3, fill to count 6 -> disp_ready=0; one issue with head advance -> count 5, disp_ready=1; wrap of tail past index 7 verified.
REQ-022 iss_ready=0 for 4 cycles with iss_valid=1 -> outputs stable; flush asserted mid-stall -> iss_valid=0, count=0 next cycle.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types and default sizes for the load/store disambiguation queue.
package lsq_pkg;

  localparam int unsigned LSQ_DEPTH  = 8;
  localparam int unsigned LSQ_DISP_W = 3;
  localparam int unsigned LSQ_N_WB   = 3;
  localparam int unsigned LSQ_PREG_W = 5;
  localparam int unsigned LSQ_TAG_W  = 5;
  localparam int unsigned LSQ_ADDR_W = 16;

  // Field widths follow the package defaults; instances must keep
  // PREG_W/TAG_W/ADDR_W equal to these.
  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic                  data_rdy;
    logic                  addr_vld;
    logic [LSQ_PREG_W-1:0] preg;
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_TAG_W-1:0]  tag;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_age_picker.sv
// Picks the oldest requesting slot of a circular queue, age measured from head.
module lsq_age_picker
  import lsq_pkg::*;
#(
  parameter int unsigned DEPTH = LSQ_DEPTH
) (
  input  logic [DEPTH-1:0]         req,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     found
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] pos;

  // Walk slots in age order starting at head; the first request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + IDX_W'(k);
      if (!found && req[pos]) begin
        found      = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsq_disamb.sv
// Unified load/store queue: in-order dispatch, wakeup/AGU capture,
// stores issue in order from the head, loads bypass non-conflicting stores.
module lsq_disamb
  import lsq_pkg::*;
#(
  parameter int unsigned DEPTH  = LSQ_DEPTH,
  parameter int unsigned DISP_W = LSQ_DISP_W,
  parameter int unsigned N_WB   = LSQ_N_WB,
  parameter int unsigned PREG_W = LSQ_PREG_W,
  parameter int unsigned TAG_W  = LSQ_TAG_W,
  parameter int unsigned ADDR_W = LSQ_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [DISP_W-1:0]              disp_valid,
  input  logic [DISP_W-1:0]              disp_is_store,
  input  logic [DISP_W-1:0][PREG_W-1:0]  disp_preg,
  input  logic [DISP_W-1:0]              disp_preg_rdy,
  input  logic [DISP_W-1:0][TAG_W-1:0]   disp_tag,
  output logic                           disp_ready,
  input  logic [N_WB-1:0]                wb_valid,
  input  logic [N_WB-1:0][PREG_W-1:0]    wb_preg,
  input  logic                           agu_valid,
  input  logic [TAG_W-1:0]               agu_tag,
  input  logic [ADDR_W-1:0]              agu_addr,
  output logic                           iss_valid,
  output logic                           iss_is_store,
  output logic [PREG_W-1:0]              iss_preg,
  output logic [ADDR_W-1:0]              iss_addr,
  output logic [TAG_W-1:0]               iss_tag,
  input  logic                           iss_ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - DISP_W);

  lsq_entry_t       q   [DEPTH];
  lsq_entry_t       q_n [DEPTH];
  lsq_entry_t       new_e;
  logic [IDX_W-1:0] head, head_n, tail, tail_n, slot;
  logic [CNT_W-1:0] count, count_n, freed, enq_cnt;
  logic             scan_stop;

  logic [IDX_W-1:0] age [DEPTH];
  logic [DEPTH-1:0] older_any, conflict, elig, grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found, take, do_issue;

  function automatic logic wb_match(input logic [PREG_W-1:0]           p,
                                    input logic [N_WB-1:0]             v,
                                    input logic [N_WB-1:0][PREG_W-1:0] pr);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < N_WB; w++)
      if (v[w] && pr[w] == p) hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = (count <= READY_MAX);
  assign take       = !iss_valid || iss_ready;
  assign do_issue   = take && pick_found;

  // Distance of each slot from head, used for older/younger ordering.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) age[i] = IDX_W'(i) - head;
  end

  // Eligibility: stores only at the front when fully ready; loads once
  // every older store has a known, different address.
  always_comb begin
    older_any = '0;
    conflict  = '0;
    elig      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (q[j].valid && age[j] < age[i]) begin
          older_any[i] = 1'b1;
          if (q[j].is_store && (!q[j].addr_vld || q[j].addr == q[i].addr))
            conflict[i] = 1'b1;
        end
      end
      elig[i] = q[i].valid && q[i].addr_vld &&
                (q[i].is_store ? (q[i].data_rdy && !older_any[i]) : !conflict[i]);
    end
  end

  lsq_age_picker #(.DEPTH(DEPTH)) u_picker (
    .req   (elig),
    .head  (head),
    .grant (grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next queue state: issue removal, wakeup/AGU, head reclaim, then enqueue.
  // Head reclaim looks at post-issue validity so a drained front frees
  // capacity on the same edge; enqueued slots lie beyond the scanned region.
  always_comb begin
    q_n       = q;
    new_e     = '0;
    slot      = '0;
    freed     = '0;
    enq_cnt   = '0;
    scan_stop = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++)
      if (do_issue && grant[i]) q_n[i].valid = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_n[i].valid) begin
        if (wb_match(q_n[i].preg, wb_valid, wb_preg)) q_n[i].data_rdy = 1'b1;
        if (agu_valid && q_n[i].tag == agu_tag) begin
          q_n[i].addr_vld = 1'b1;
          q_n[i].addr     = agu_addr;
        end
      end
    end

    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + IDX_W'(k);
      if (!scan_stop && CNT_W'(k) < count && !q_n[slot].valid)
        freed = freed + CNT_W'(1);
      else
        scan_stop = 1'b1;
    end

    if (disp_ready) begin
      for (int unsigned p = 0; p < DISP_W; p++) begin
        if (disp_valid[p]) begin
          new_e.valid    = 1'b1;
          new_e.is_store = disp_is_store[p];
          new_e.data_rdy = !disp_is_store[p] || disp_preg_rdy[p] ||
                           wb_match(disp_preg[p], wb_valid, wb_preg);
          new_e.addr_vld = agu_valid && (disp_tag[p] == agu_tag);
          new_e.addr     = new_e.addr_vld ? agu_addr : '0;
          new_e.preg     = disp_preg[p];
          new_e.tag      = disp_tag[p];
          slot           = tail + enq_cnt[IDX_W-1:0];
          q_n[slot]      = new_e;
          enq_cnt        = enq_cnt + CNT_W'(1);
        end
      end
    end

    head_n  = head + freed[IDX_W-1:0];
    tail_n  = tail + enq_cnt[IDX_W-1:0];
    count_n = count - freed + enq_cnt;
  end

  // Queue storage and pointers; flush overrides all same-cycle activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_n[i];
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  // Issue register: reloads when empty or accepted, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid    <= 1'b0;
      iss_is_store <= 1'b0;
      iss_preg     <= '0;
      iss_addr     <= '0;
      iss_tag      <= '0;
    end else if (flush) begin
      iss_valid    <= 1'b0;
      iss_is_store <= 1'b0;
      iss_preg     <= '0;
      iss_addr     <= '0;
      iss_tag      <= '0;
    end else if (take) begin
      iss_valid <= pick_found;
      if (pick_found) begin
        iss_is_store <= q[pick_idx].is_store;
        iss_preg     <= q[pick_idx].preg;
        iss_addr     <= q[pick_idx].addr;
        iss_tag      <= q[pick_idx].tag;
      end
    end
  end

endmodule

// File: tb/tb_lsq_disamb.sv
// Scenario bench for lsq_disamb with an expected-issue scoreboard.
module tb_lsq_disamb;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DISP_W = 3;
  localparam int unsigned N_WB   = 3;
  localparam int unsigned PREG_W = 5;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned ADDR_W = 16;

  typedef logic [PREG_W+ADDR_W+TAG_W:0] item_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [DISP_W-1:0]             disp_valid, disp_is_store, disp_preg_rdy;
  logic [DISP_W-1:0][PREG_W-1:0] disp_preg;
  logic [DISP_W-1:0][TAG_W-1:0]  disp_tag;
  logic                          disp_ready;
  logic [N_WB-1:0]               wb_valid;
  logic [N_WB-1:0][PREG_W-1:0]   wb_preg;
  logic                          agu_valid;
  logic [TAG_W-1:0]              agu_tag;
  logic [ADDR_W-1:0]             agu_addr;
  logic                          iss_valid, iss_is_store, iss_ready;
  logic [PREG_W-1:0]             iss_preg;
  logic [ADDR_W-1:0]             iss_addr;
  logic [TAG_W-1:0]              iss_tag;

  item_t exp_q[$];
  item_t obs_q[$];
  int    checks   = 0;
  int    failures = 0;

  lsq_disamb #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .N_WB(N_WB),
    .PREG_W(PREG_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store),
    .disp_preg(disp_preg), .disp_preg_rdy(disp_preg_rdy),
    .disp_tag(disp_tag), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
    .iss_valid(iss_valid), .iss_is_store(iss_is_store), .iss_preg(iss_preg),
    .iss_addr(iss_addr), .iss_tag(iss_tag), .iss_ready(iss_ready)
  );

  always #5 clk = ~clk;

  // Record every accepted issue for the scenarios to score.
  always @(negedge clk)
    if (rst && iss_valid && iss_ready)
      obs_q.push_back({iss_is_store, iss_preg, iss_addr, iss_tag});

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  function automatic item_t mk(input logic st, input logic [PREG_W-1:0] p,
                               input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    return {st, p, a, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; disp_valid = '0; disp_is_store = '0; disp_preg_rdy = '0;
    disp_preg = '0; disp_tag = '0; wb_valid = '0; wb_preg = '0;
    agu_valid = 1'b0; agu_tag = '0; agu_addr = '0;
  endtask

  task automatic set_disp(input int p, input logic st, input logic [PREG_W-1:0] pr,
                          input logic rdy, input logic [TAG_W-1:0] t);
    disp_valid[p] = 1'b1; disp_is_store[p] = st; disp_preg[p] = pr;
    disp_preg_rdy[p] = rdy; disp_tag[p] = t;
  endtask

  task automatic set_agu(input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] a);
    agu_valid = 1'b1; agu_tag = t; agu_addr = a;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin tick(); c++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0; iss_ready = 1'b1; clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    checks++;
    if ({iss_is_store, iss_preg, iss_addr, iss_tag} !== item_t'(0)) begin
      failures++; $display("FAIL reset_iss_fields got=%h exp=0", {iss_is_store, iss_preg, iss_addr, iss_tag});
    end
    checks++;
    if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    @(posedge clk); #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_addr_ready_load();
    bit ok; item_t g, e;
    set_disp(0, 0, 1, 0, 1); set_disp(1, 0, 2, 0, 2); set_disp(2, 0, 3, 0, 3);
    tick(); clear_inputs();
    set_agu(2, 16'h0040); exp_q.push_back(mk(0, 2, 16'h0040, 2)); tick();
    set_agu(3, 16'h0030); exp_q.push_back(mk(0, 3, 16'h0030, 3)); tick();
    set_agu(1, 16'h0010); exp_q.push_back(mk(0, 1, 16'h0010, 1)); tick();
    clear_inputs();
    repeat (3) begin
      wait_obs(1, 20, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL addr_ready_order timeout exp=%h", e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL addr_ready_order got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_load_bypass();
    bit ok; item_t g, e;
    set_disp(0, 1, 10, 0, 4); set_disp(1, 0, 11, 0, 5);
    tick(); clear_inputs();
    set_agu(4, 16'h0100); tick();
    set_agu(5, 16'h0200); exp_q.push_back(mk(0, 11, 16'h0200, 5)); tick();
    clear_inputs();
    wait_obs(1, 20, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL bypass_load timeout exp=%h", e); end
    else begin
      g = obs_q.pop_front();
      if (g !== e) begin failures++; $display("FAIL bypass_load got=%h exp=%h", g, e); end
    end
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL store_before_data got=%0d issues exp=0", obs_q.size()); end
    wb_valid[2] = 1'b1; wb_preg[2] = 10; exp_q.push_back(mk(1, 10, 16'h0100, 4));
    tick(); clear_inputs();
    wait_obs(1, 20, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL bypass_store timeout exp=%h", e); end
    else begin
      g = obs_q.pop_front();
      if (g !== e) begin failures++; $display("FAIL bypass_store got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_load_conflict();
    bit ok; item_t g, e;
    set_disp(0, 1, 12, 0, 6); set_disp(1, 0, 13, 0, 7);
    tick(); clear_inputs();
    set_agu(6, 16'h0100); tick();
    set_agu(7, 16'h0100); tick();
    clear_inputs();
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL conflict_blocked got=%0d issues exp=0", obs_q.size()); end
    wb_valid[0] = 1'b1; wb_preg[0] = 12;
    exp_q.push_back(mk(1, 12, 16'h0100, 6)); exp_q.push_back(mk(0, 13, 16'h0100, 7));
    tick(); clear_inputs();
    repeat (2) begin
      wait_obs(1, 20, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL conflict_order timeout exp=%h", e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL conflict_order got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_capacity_wrap();
    bit ok; item_t g, e;
    set_disp(0, 0, 1, 0, 8); set_disp(1, 0, 2, 0, 9); set_disp(2, 0, 3, 0, 10);
    tick(); clear_inputs();
    @(negedge clk);
    checks++;
    if (dut.tail !== 3'd2) begin failures++; $display("FAIL tail_wrap got=%0d exp=2", dut.tail); end
    @(posedge clk); #1;
    set_disp(0, 0, 4, 0, 11); set_disp(1, 0, 5, 0, 12); set_disp(2, 0, 6, 0, 13);
    tick(); clear_inputs();
    @(negedge clk);
    checks++;
    if (dut.count !== 4'd6) begin failures++; $display("FAIL full_count got=%0d exp=6", dut.count); end
    checks++;
    if (disp_ready !== 1'b0) begin failures++; $display("FAIL full_disp_ready got=%b exp=0", disp_ready); end
    @(posedge clk); #1;
    set_disp(0, 0, 7, 0, 20);
    tick(); clear_inputs();
    @(negedge clk);
    checks++;
    if (dut.count !== 4'd6) begin failures++; $display("FAIL blocked_dispatch count got=%0d exp=6", dut.count); end
    @(posedge clk); #1;
    set_agu(8, 16'h0800); exp_q.push_back(mk(0, 1, 16'h0800, 8));
    tick(); clear_inputs();
    wait_obs(1, 20, ok);
    checks++;
    if (dut.count !== 4'd5) begin failures++; $display("FAIL freed_count got=%0d exp=5", dut.count); end
    checks++;
    if (disp_ready !== 1'b1) begin failures++; $display("FAIL freed_disp_ready got=%b exp=1", disp_ready); end
    for (int t = 9; t <= 13; t++) begin
      set_agu(TAG_W'(t), ADDR_W'(16'h0900 + t));
      exp_q.push_back(mk(0, PREG_W'(t - 7), ADDR_W'(16'h0900 + t), TAG_W'(t)));
      tick();
    end
    clear_inputs();
    repeat (6) begin
      wait_obs(1, 20, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL wrap_order timeout exp=%h", e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL wrap_order got=%h exp=%h", g, e); end
      end
    end
    repeat (3) tick();
    checks++;
    if (dut.count !== 4'd0) begin failures++; $display("FAIL drained_count got=%0d exp=0", dut.count); end
  endtask

  task automatic test_stall_flush();
    bit seen = 1'b0;
    item_t held = mk(0, 14, 16'h0abc, 14);
    iss_ready = 1'b0;
    set_disp(0, 0, 14, 0, 14); set_disp(1, 0, 15, 0, 15); set_agu(14, 16'h0abc);
    tick(); clear_inputs();
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = iss_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL stall_issue timeout got=0 exp=1"); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b1 || {iss_is_store, iss_preg, iss_addr, iss_tag} !== held) begin
        failures++;
        $display("FAIL stall_hold got=%b/%h exp=1/%h", iss_valid, {iss_is_store, iss_preg, iss_addr, iss_tag}, held);
      end
    end
    @(posedge clk); #1;
    flush = 1'b1; set_agu(15, 16'h0123);
    tick(); clear_inputs();
    @(negedge clk);
    checks++;
    if (iss_valid !== 1'b0) begin failures++; $display("FAIL flush_iss_valid got=%b exp=0", iss_valid); end
    checks++;
    if (dut.count !== 4'd0 || dut.head !== 3'd0 || dut.tail !== 3'd0) begin
      failures++; $display("FAIL flush_ptrs got=%0d/%0d/%0d exp=0/0/0", dut.count, dut.head, dut.tail);
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL stall_accept got=%0d exp=0", obs_q.size()); end
    @(posedge clk); #1 iss_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 0 || iss_valid !== 1'b0) begin
      failures++; $display("FAIL post_flush_issue got=%0d/%b exp=0/0", obs_q.size(), iss_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; item_t g, e;
    set_disp(0, 1, 20, 0, 16); wb_valid[1] = 1'b1; wb_preg[1] = 20; set_agu(16, 16'h0300);
    exp_q.push_back(mk(1, 20, 16'h0300, 16));
    tick(); clear_inputs();
    set_disp(0, 1, 22, 1, 17); set_agu(17, 16'h0304);
    exp_q.push_back(mk(1, 22, 16'h0304, 17));
    tick(); clear_inputs();
    repeat (2) begin
      wait_obs(1, 20, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_store timeout exp=%h", e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin failures++; $display("FAIL b2b_store got=%h exp=%h", g, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_ready_load();
    test_load_bypass();
    test_load_conflict();
    test_capacity_wrap();
    test_stall_flush();
    test_back_to_back();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
